telemetry_counter_gen: RTL and testbench
========================================

TELEMETRY_COUNTER_GEN -- requirements
Module: telemetry_counter_gen

Interface
REQ-001 Parameter g_period, 16 bits, default 16'd410: clk_256M cycles between counter packets (about 1.6 us); legal range 2..65535.
REQ-002 Parameter g_stream_id, 4 bits, default 4'hD: stream/class id placed in packet_data[83:80].
REQ-003 clk_256M  in  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 enable  in  1  level; high = generate packets.
REQ-006 packet_ready  in  1  downstream accepts packet when high with packet_valid.
REQ-007 inject_skip  in  1  single-cycle pulse; next loaded packet skips one count value.
REQ-008 inject_corrupt  in  1  single-cycle pulse; next loaded packet has count bit 0 inverted.
REQ-009 clear_counters  in  1  synchronous clear of statistics.
REQ-010 packet_data  out  88  packet word.
REQ-011 packet_valid  out  1  packet_data holds a packet.
REQ-012 sent_packets  out  32  accepted-packet count.
REQ-013 dropped_ticks  out  16  period ticks lost to backpressure, saturating.
REQ-014 running  out  1  high when state is not IDLE.

Function
REQ-015 Packet format: [87:84]=0, [83:80]=g_stream_id, [79:10]=0, [9:0]=count field.
REQ-016 The block has three states, IDLE, WAIT and SEND, held in a registered FSM.
REQ-017 Period timer: 16 bits; clears in IDLE; in WAIT/SEND counts 0..g_period-1 then wraps to 0; tick = timer==g_period-1.
REQ-018 IDLE->WAIT when enable sampled high; timer=0 on the first WAIT cycle.
REQ-019 WAIT->SEND on tick: packet_data loaded and packet_valid=1 the next cycle; first valid therefore appears exactly g_period+1 cycles after the cycle enable is first sampled high.
REQ-020 In SEND, packet_valid and packet_data stay stable until the cycle in which packet_valid and packet_ready are both high (the handshake).
REQ-021 On handshake: packet_valid=0 next cycle; next state is WAIT if enable is high, otherwise IDLE; the timer keeps running, with no restart.
REQ-022 Tick while in SEND (not the handshake cycle) -> packet not generated, dropped_ticks+1 (saturate at 16'hFFFF); tick coincident with handshake also counts as dropped.
REQ-023 WAIT with enable low -> IDLE next cycle; SEND with enable low -> complete the current packet, then IDLE.
REQ-024 Count register c (10 bits, wraps 3FF->000) holds the next value to send; it advances only on handshake, never on dropped ticks.
REQ-025 inject_skip and inject_corrupt pulses set sticky flags; the flags apply at the next WAIT->SEND load and clear at that load; a pulse in the load cycle applies to the following packet.
REQ-026 Load arithmetic: c_eff = skip ? c+1 : c (mod 1024); field [9:0] = c_eff XOR {9'b0, corrupt}; on handshake c <= c_eff+1 (mod 1024).
REQ-027 sent_packets +1 per handshake, wrapping at 2^32; clear_counters zeroes sent_packets and dropped_ticks and has priority over a simultaneous increment.
REQ-028 running = (state != IDLE), registered.

Reset
REQ-029 rst_n low at a clock edge -> next cycle: state IDLE, timer 0, c 0, flags 0, packet_valid 0, packet_data 0, sent_packets 0, dropped_ticks 0, running 0; this applies in any state, including mid-SEND.
REQ-030 Reset has priority over enable, clear_counters and handshake.

Verification
REQ-031 g_period=8, ready=1, enable raised at cycle N -> first valid at cycle N+9 and every 8 cycles after; [83:80]=D; [9:0]=0,1,2...; sent_packets tracks the number of packets.
REQ-032 Run 1026 packets with ready=1 -> [9:0] shows ...3FE,3FF,000,001; sent_packets=1026; dropped_ticks=0.
REQ-033 g_period=8, ready held low 20 cycles while valid -> data stable throughout, dropped_ticks=2; after ready the count field continues with no gap.
REQ-034 inject_skip pulsed while c=5 -> sequence 4,6,7 when the pulse precedes the load of 5 (the pulse is sampled before the 4->5 load); same-cycle-as-load pulse -> applies to the following packet.
REQ-035 inject_corrupt pulsed before the load of 5 -> sequence 3,4,4,6,7 (a telemetry receiver counts 2 mismatches).
REQ-036 enable dropped during SEND with ready low -> valid held until ready, then IDLE and running=0; rst_n low mid-SEND -> packet_valid=0 and all counters 0 next cycle.

Source files
------------

// File: rtl/telemetry_counter_gen.sv
// Telemetry counter packet generator.
// Emits one 88-bit counter packet every g_period clk_256M cycles while enabled,
// holding each packet under valid/ready backpressure. Periods that fall while a
// packet is still pending are counted as dropped ticks. Single-cycle pulses can
// inject a skipped count value or a corrupted count bit into the next packet.
//
// Ports:
//   clk_256M        sole clock, rising edge
//   rst_n           synchronous active-low reset
//   enable          level, high = generate packets
//   packet_ready    downstream accept (handshake with packet_valid)
//   inject_skip     pulse: next loaded packet skips one count value
//   inject_corrupt  pulse: next loaded packet has count bit 0 inverted
//   clear_counters  synchronous clear of sent_packets / dropped_ticks
//   packet_data     packet word {4'h0, g_stream_id, 70'h0, count[9:0]}
//   packet_valid    packet_data holds a packet
//   sent_packets    accepted-packet count, wrapping
//   dropped_ticks   period ticks lost to backpressure, saturating
//   running         high when not IDLE
module telemetry_counter_gen #(
    parameter logic [15:0] g_period    = 16'd410,
    parameter logic [3:0]  g_stream_id = 4'hD
) (
    input  logic        clk_256M,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        packet_ready,
    input  logic        inject_skip,
    input  logic        inject_corrupt,
    input  logic        clear_counters,
    output logic [87:0] packet_data,
    output logic        packet_valid,
    output logic [31:0] sent_packets,
    output logic [15:0] dropped_ticks,
    output logic        running
);

    localparam int unsigned TIMER_W = 16;
    localparam int unsigned CNT_W   = 10;
    localparam int unsigned DATA_W  = 88;
    localparam int unsigned SENT_W  = 32;
    localparam int unsigned DROP_W  = 16;
    localparam int unsigned PAD_W   = DATA_W - 8 - CNT_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [TIMER_W-1:0] timer_q;
    logic [CNT_W-1:0]   count_q;
    logic               skip_q;
    logic               corrupt_q;

    logic               tick;
    logic               handshake;
    logic               load;
    logic [CNT_W-1:0]   count_eff;

    // Control decode and next-state logic.
    always_comb begin
        state_d   = state_q;
        tick      = (state_q != ST_IDLE) && (timer_q == g_period - TIMER_W'(1));
        handshake = (state_q == ST_SEND) && packet_valid && packet_ready;
        load      = (state_q == ST_WAIT) && enable && tick;
        count_eff = skip_q ? count_q + CNT_W'(1) : count_q;

        case (state_q)
            ST_IDLE: if (enable) state_d = ST_WAIT;
            ST_WAIT: begin
                // Disable wins over a coincident tick: no packet is loaded.
                if (!enable)   state_d = ST_IDLE;
                else if (tick) state_d = ST_SEND;
            end
            ST_SEND: if (handshake) state_d = enable ? ST_WAIT : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_256M) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Timer, count, inject flags, packet and statistics registers.
    always_ff @(posedge clk_256M) begin
        if (!rst_n) begin
            timer_q       <= '0;
            count_q       <= '0;
            skip_q        <= 1'b0;
            corrupt_q     <= 1'b0;
            packet_data   <= '0;
            packet_valid  <= 1'b0;
            sent_packets  <= '0;
            dropped_ticks <= '0;
            running       <= 1'b0;
        end else begin
            // Timer free-runs through WAIT and SEND; it is held at zero in IDLE
            // so the first WAIT cycle always starts a fresh period.
            if (state_q == ST_IDLE || state_d == ST_IDLE) timer_q <= '0;
            else if (tick)                                timer_q <= '0;
            else                                          timer_q <= timer_q + TIMER_W'(1);

            // Flags are consumed by a load; a pulse in the load cycle re-arms them.
            skip_q    <= load ? inject_skip    : (skip_q    | inject_skip);
            corrupt_q <= load ? inject_corrupt : (corrupt_q | inject_corrupt);

            // count_q holds c_eff while a packet is pending, so +1 on handshake
            // yields c_eff+1 without a separate register.
            if (load) begin
                count_q      <= count_eff;
                packet_data  <= {4'h0, g_stream_id, {PAD_W{1'b0}},
                                 count_eff ^ {{(CNT_W-1){1'b0}}, corrupt_q}};
                packet_valid <= 1'b1;
            end else if (handshake) begin
                count_q      <= count_q + CNT_W'(1);
                packet_valid <= 1'b0;
            end

            if (clear_counters) sent_packets <= '0;
            else if (handshake) sent_packets <= sent_packets + SENT_W'(1);

            if (clear_counters)
                dropped_ticks <= '0;
            else if (state_q == ST_SEND && tick && dropped_ticks != '1)
                dropped_ticks <= dropped_ticks + DROP_W'(1);

            running <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_telemetry_counter_gen.sv
// Directed bench for telemetry_counter_gen with g_period = 8.
module tb_telemetry_counter_gen;

    localparam logic [15:0] P = 16'd8;

    logic        clk_256M = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        packet_ready;
    logic        inject_skip;
    logic        inject_corrupt;
    logic        clear_counters;
    logic [87:0] packet_data;
    logic        packet_valid;
    logic [31:0] sent_packets;
    logic [15:0] dropped_ticks;
    logic        running;

    always #2 clk_256M = ~clk_256M;

    telemetry_counter_gen #(.g_period(P), .g_stream_id(4'hD)) dut (
        .clk_256M       (clk_256M),
        .rst_n          (rst_n),
        .enable         (enable),
        .packet_ready   (packet_ready),
        .inject_skip    (inject_skip),
        .inject_corrupt (inject_corrupt),
        .clear_counters (clear_counters),
        .packet_data    (packet_data),
        .packet_valid   (packet_valid),
        .sent_packets   (sent_packets),
        .dropped_ticks  (dropped_ticks),
        .running        (running)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          d;     // cycles ready is held low after valid
        logic        sk;    // inject_skip pulse early in the period
        logic        cr;    // inject_corrupt pulse early in the period
        logic [9:0]  f;     // expected count field
        int          gap;   // expected cycles until valid
        logic [15:0] drop;  // expected dropped_ticks after handshake
    } rec_t;

    rec_t tbl [10];

    task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_256M);
        #1;
    endtask

    function automatic logic [87:0] pkt(input logic [9:0] f);
        pkt = {4'h0, 4'hD, 70'd0, f};
    endfunction

    // Steps until packet_valid is seen; injects are pulsed in the first cycle.
    task automatic wait_valid(input int max, input logic sk, input logic cr, output int n);
        n = 0;
        inject_skip    = sk;
        inject_corrupt = cr;
        do begin
            step();
            inject_skip    = 1'b0;
            inject_corrupt = 1'b0;
            n++;
        end while (!packet_valid && n < max);
        if (!packet_valid) begin
            total++;
            bad++;
            $display("FAIL wait_valid: no packet within %0d cycles", max);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        tbl[0] = '{0,  1'b0, 1'b0, 10'd0,  9, 16'd0};
        tbl[1] = '{0,  1'b0, 1'b0, 10'd1,  7, 16'd0};
        tbl[2] = '{20, 1'b0, 1'b0, 10'd2,  7, 16'd2};
        tbl[3] = '{0,  1'b0, 1'b0, 10'd3,  3, 16'd2};
        tbl[4] = '{0,  1'b0, 1'b0, 10'd4,  7, 16'd2};
        tbl[5] = '{0,  1'b1, 1'b0, 10'd6,  7, 16'd2};
        tbl[6] = '{0,  1'b0, 1'b0, 10'd7,  7, 16'd2};
        tbl[7] = '{0,  1'b0, 1'b1, 10'd9,  7, 16'd2};
        tbl[8] = '{0,  1'b0, 1'b0, 10'd9,  7, 16'd2};
        tbl[9] = '{0,  1'b0, 1'b0, 10'd10, 7, 16'd2};

        // Reset state, with enable high to show reset priority.
        rst_n = 1'b0; enable = 1'b1; packet_ready = 1'b0;
        inject_skip = 1'b0; inject_corrupt = 1'b0; clear_counters = 1'b0;
        repeat (3) step();
        chk("rst_valid",   88'(packet_valid),  88'(0));
        chk("rst_data",    packet_data,        88'(0));
        chk("rst_sent",    88'(sent_packets),  88'(0));
        chk("rst_dropped", 88'(dropped_ticks), 88'(0));
        chk("rst_running", 88'(running),       88'(0));
        enable = 1'b0;
        rst_n  = 1'b1;
        step();
        chk("idle_running", 88'(running), 88'(0));

        // Table: latency, period, backpressure, skip and corrupt.
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_valid(40, tbl[i].sk, tbl[i].cr, n);
            chk($sformatf("gap[%0d]", i),  88'(n), 88'(tbl[i].gap));
            chk($sformatf("data[%0d]", i), packet_data, pkt(tbl[i].f));
            chk($sformatf("run[%0d]", i),  88'(running), 88'(1));
            for (int j = 0; j < tbl[i].d; j++) begin
                step();
                chk($sformatf("hold_v[%0d]", i), 88'(packet_valid), 88'(1));
                chk($sformatf("hold_d[%0d]", i), packet_data, pkt(tbl[i].f));
            end
            packet_ready = 1'b1;
            step();
            packet_ready = 1'b0;
            chk($sformatf("hs_valid[%0d]", i), 88'(packet_valid),  88'(0));
            chk($sformatf("hs_sent[%0d]", i),  88'(sent_packets),  88'(i + 1));
            chk($sformatf("hs_drop[%0d]", i),  88'(dropped_ticks), 88'(tbl[i].drop));
        end

        // Skip pulse in the load cycle applies to the following packet.
        repeat (6) step();
        chk("preload_valid", 88'(packet_valid), 88'(0));
        inject_skip = 1'b1;
        step();
        inject_skip = 1'b0;
        chk("load_valid", 88'(packet_valid), 88'(1));
        chk("load_data",  packet_data, pkt(10'd11));
        packet_ready = 1'b1;
        step();
        packet_ready = 1'b0;
        wait_valid(20, 1'b0, 1'b0, n);
        chk("late_skip_gap",  88'(n), 88'(7));
        chk("late_skip_data", packet_data, pkt(10'd13));

        // Clear wins over a simultaneous handshake increment.
        packet_ready = 1'b1; clear_counters = 1'b1;
        step();
        packet_ready = 1'b0; clear_counters = 1'b0;
        chk("clr_sent",    88'(sent_packets),  88'(0));
        chk("clr_dropped", 88'(dropped_ticks), 88'(0));
        chk("clr_valid",   88'(packet_valid),  88'(0));

        // Disable during SEND: packet completes, then IDLE.
        wait_valid(20, 1'b0, 1'b0, n);
        chk("dis_data0", packet_data, pkt(10'd14));
        enable = 1'b0;
        repeat (3) begin
            step();
            chk("dis_valid", 88'(packet_valid), 88'(1));
            chk("dis_data",  packet_data, pkt(10'd14));
            chk("dis_run",   88'(running), 88'(1));
        end
        packet_ready = 1'b1;
        step();
        packet_ready = 1'b0;
        chk("dis_hs_valid", 88'(packet_valid), 88'(0));
        chk("dis_hs_run",   88'(running),      88'(0));
        chk("dis_hs_sent",  88'(sent_packets), 88'(1));
        repeat (10) step();
        chk("idle_valid", 88'(packet_valid), 88'(0));
        chk("idle_run",   88'(running),      88'(0));

        // Reset mid-SEND after one dropped tick.
        enable = 1'b1;
        wait_valid(40, 1'b0, 1'b0, n);
        chk("re_gap",  88'(n), 88'(9));
        chk("re_data", packet_data, pkt(10'd15));
        repeat (10) step();
        chk("pre_rst_drop", 88'(dropped_ticks), 88'(1));
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", 88'(packet_valid),  88'(0));
        chk("mid_rst_data",  packet_data,        88'(0));
        chk("mid_rst_sent",  88'(sent_packets),  88'(0));
        chk("mid_rst_drop",  88'(dropped_ticks), 88'(0));
        chk("mid_rst_run",   88'(running),       88'(0));
        rst_n = 1'b1;
        wait_valid(40, 1'b0, 1'b0, n);
        chk("post_rst_gap",  88'(n), 88'(9));
        chk("post_rst_data", packet_data, pkt(10'd0));

        // 1026 packets with ready held high: count field wraps.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        packet_ready = 1'b1;
        for (int k = 0; k < 1026; k++) begin
            wait_valid(20, 1'b0, 1'b0, n);
            chk("wrap_gap",  88'(n), 88'((k == 0) ? 9 : 8));
            chk("wrap_data", packet_data, pkt(10'(k)));
        end
        step();
        packet_ready = 1'b0;
        chk("wrap_sent", 88'(sent_packets),  88'(1026));
        chk("wrap_drop", 88'(dropped_ticks), 88'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
